// File: rtl/imm_gen_stage.sv
// imm_gen_stage
// Registered immediate-generation stage for the RV decode path, sitting
// between fetch and execute. Decodes the instruction format from the opcode,
// assembles the sign-extended immediate for I/S/B/U/J, computes the
// PC-relative target for branches and JAL, and flags jumps and branches.
// All results live in a single output register with valid/ready handshake.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset, clears every register
//   instr_in   - 32-bit instruction word
//   pc_in      - PC of instr_in (XLEN bits)
//   in_valid   - instr_in/pc_in are valid
//   in_ready   - stage can accept a new instruction this cycle
//   flush      - synchronous kill of the stage contents
//   out_ready  - downstream accepts the current result this cycle
//   out_valid  - output register holds a live result
//   imm_out    - sign-extended immediate
//   fmt_out    - 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//   jump_out   - JAL or JALR
//   branch_out - BRANCH opcode
//   target_out - pc + imm for B/J formats, otherwise 0
module imm_gen_stage #(
  parameter int XLEN   = 32,
  parameter bit RV64_W = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt_out,
  output logic            jump_out,
  output logic            branch_out,
  output logic [XLEN-1:0] target_out
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  // OP-IMM-32 only exists on RV64 builds that enable the W instructions.
  localparam bit W_DECODE = RV64_W && (XLEN == 64);

  logic [6:0]      opcode;
  fmt_e            fmt_d;
  logic [31:0]     imm32_d;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] target_d;
  logic            jump_d;
  logic            branch_d;
  logic            capture;

  assign opcode = instr_in[6:0];

  // Format decode and raw 32-bit immediate assembly. Every non-zero format
  // places instr[31] in bit 31, so a single sign extension of the 32-bit
  // pattern gives the XLEN result for all formats, U included.
  always_comb begin
    fmt_d   = FMT_NONE;
    imm32_d = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        fmt_d   = FMT_I;
        imm32_d = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      OP_IMM_32: begin
        if (W_DECODE) begin
          fmt_d   = FMT_I;
          imm32_d = {{20{instr_in[31]}}, instr_in[31:20]};
        end
      end
      OP_STORE: begin
        fmt_d   = FMT_S;
        imm32_d = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end
      OP_BRANCH: begin
        fmt_d   = FMT_B;
        imm32_d = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                   instr_in[30:25], instr_in[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d   = FMT_U;
        imm32_d = {instr_in[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_d   = FMT_J;
        imm32_d = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                   instr_in[20], instr_in[30:21], 1'b0};
      end
      default: begin
        fmt_d   = FMT_NONE;
        imm32_d = '0;
      end
    endcase
  end

  // Sign-extend to XLEN and form the PC-relative target. JALR is excluded
  // from the target because it depends on rs1, which is only known in execute.
  always_comb begin
    imm_d    = XLEN'(signed'(imm32_d));
    target_d = '0;
    if (fmt_d == FMT_B || fmt_d == FMT_J) begin
      target_d = pc_in + imm_d;
    end
    jump_d   = (opcode == OP_JAL) || (opcode == OP_JALR);
    branch_d = (opcode == OP_BRANCH);
  end

  // The stage is free when empty or when its current result leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  // Output pipeline register. Flush wins over capture and consume; on a
  // plain consume only the valid bit drops and the data keeps its old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      imm_out    <= '0;
      fmt_out    <= 3'd0;
      jump_out   <= 1'b0;
      branch_out <= 1'b0;
      target_out <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      imm_out    <= imm_d;
      fmt_out    <= fmt_d;
      jump_out   <= jump_d;
      branch_out <= branch_d;
      target_out <= target_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
